// File: rtl/fetch_queue.sv
// Dual-slot fetch queue: circular {pc, inst} FIFO between fetch and check.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 13
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push_valid1,
  input  logic                     push_valid2,
  input  logic [PC_W-1:0]          push_pc1,
  input  logic [PC_W-1:0]          push_pc2,
  input  logic [31:0]              push_inst1,
  input  logic [31:0]              push_inst2,
  output logic                     push_ready,
  input  logic                     flush,
  input  logic [1:0]               pop_count,
  output logic                     pop_valid1,
  output logic                     pop_valid2,
  output logic [PC_W-1:0]          pop_pc1,
  output logic [PC_W-1:0]          pop_pc2,
  output logic [31:0]              pop_inst1,
  output logic [31:0]              pop_inst2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic [AW-1:0]   head, tail;
  logic [AW-1:0]   head1;
  logic [1:0]      pushes, pop_req, pops;
  logic [1:0]      byp_n, wr_n, head_adv;
  logic [CW-1:0]   avail;
  logic            byp;
  logic [PC_W-1:0] w0_pc;
  logic [31:0]     w0_inst;

  assign head1 = head + AW'(1);

  always_comb begin
    push_ready = count <= CW'(DEPTH - 2);
    pushes = 2'd0;
    if (push_ready && push_valid1)
      pushes = push_valid2 ? 2'd2 : 2'd1;
    pop_req = (pop_count == 2'd3) ? 2'd2 : pop_count;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (count == '0) && !flush;
`endif
    // When bypassing, pops draw from this cycle's pushes instead of storage
    avail = byp ? CW'(pushes) : count;
    pops = (CW'(pop_req) > avail) ? avail[1:0] : pop_req;
    byp_n = byp ? pops : 2'd0;
    head_adv = byp ? 2'd0 : pops;
    wr_n = pushes - byp_n;
    w0_pc   = (byp_n == 2'd1) ? push_pc2   : push_pc1;
    w0_inst = (byp_n == 2'd1) ? push_inst2 : push_inst1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + CW'(pushes) - CW'(pops);
      head  <= head + AW'(head_adv);
      tail  <= tail + AW'(wr_n);
    end
  end

  // Storage is never reset; occupancy alone decides what is visible
  always_ff @(posedge CLK) begin
    if (!flush && wr_n != 2'd0) begin
      pc_mem[tail]   <= w0_pc;
      inst_mem[tail] <= w0_inst;
    end
    if (!flush && wr_n == 2'd2) begin
      pc_mem[tail + AW'(1)]   <= push_pc2;
      inst_mem[tail + AW'(1)] <= push_inst2;
    end
  end

  always_comb begin
    pop_valid1 = count >= CW'(1);
    pop_valid2 = count >= CW'(2);
    pop_pc1    = pop_valid1 ? pc_mem[head]    : '0;
    pop_inst1  = pop_valid1 ? inst_mem[head]  : NOP;
    pop_pc2    = pop_valid2 ? pc_mem[head1]   : '0;
    pop_inst2  = pop_valid2 ? inst_mem[head1] : NOP;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (byp && !RST) begin
      pop_valid1 = push_valid1;
      pop_valid2 = push_valid1 && push_valid2;
      pop_pc1    = pop_valid1 ? push_pc1   : '0;
      pop_inst1  = pop_valid1 ? push_inst1 : NOP;
      pop_pc2    = pop_valid2 ? push_pc2   : '0;
      pop_inst2  = pop_valid2 ? push_inst2 : NOP;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed stimulus, queue-based expectations.
// Monitor compares pop outputs against the expected queue every negedge.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 13;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            CLK = 1'b0;
  logic            RST;
  logic            push_valid1, push_valid2;
  logic [PC_W-1:0] push_pc1, push_pc2;
  logic [31:0]     push_inst1, push_inst2;
  logic            push_ready;
  logic            flush;
  logic [1:0]      pop_count;
  logic            pop_valid1, pop_valid2;
  logic [PC_W-1:0] pop_pc1, pop_pc2;
  logic [31:0]     pop_inst1, pop_inst2;
  logic [3:0]      count;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_v[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK(CLK), .RST(RST),
    .push_valid1(push_valid1), .push_valid2(push_valid2),
    .push_pc1(push_pc1), .push_pc2(push_pc2),
    .push_inst1(push_inst1), .push_inst2(push_inst2),
    .push_ready(push_ready), .flush(flush),
    .pop_count(pop_count),
    .pop_valid1(pop_valid1), .pop_valid2(pop_valid2),
    .pop_pc1(pop_pc1), .pop_pc2(pop_pc2),
    .pop_inst1(pop_inst1), .pop_inst2(pop_inst2),
    .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ins(input logic [PC_W-1:0] pc);
    if (pc == 13'h004) return 32'h0020_0113;
    return {12'(pc >> 2) + 12'd1, 20'h00093};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v1, input bit v2,
                       input logic [PC_W-1:0] pc,
                       input logic [1:0] pop, input bit fl);
    push_valid1 = v1;
    push_valid2 = v2;
    push_pc1    = pc;
    push_pc2    = pc + 13'h004;
    push_inst1  = ins(pc);
    push_inst2  = ins(pc + 13'h004);
    pop_count   = pop;
    flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 13'h000, 2'd0, 1'b0);
  endtask

  // Expected effect of one edge: accepted pushes appended, then npop removed
  task automatic commit(input bit fl, input bit acc, input int npop);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (acc && push_valid1) begin
        exp_q.push_back({push_pc1, push_inst1});
        if (push_valid2) exp_q.push_back({push_pc2, push_inst2});
      end
      repeat (npop) void'(exp_q.pop_front());
    end
  endtask

  task automatic step(input bit v1, input bit v2,
                      input logic [PC_W-1:0] pc,
                      input logic [1:0] pop, input bit fl,
                      input bit acc, input int npop);
    drive(v1, v2, pc, pop, fl);
    @(posedge CLK);
    commit(fl, acc, npop);
    #1 idle();
  endtask

  task automatic realign();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (started && !RST) begin
      mon_v = exp_q;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (mon_v.size() == 0 && !flush && push_valid1) begin
        mon_v.push_back({push_pc1, push_inst1});
        if (push_valid2) mon_v.push_back({push_pc2, push_inst2});
      end
`endif
      chk("mon_count", 32'(count), 32'(exp_q.size()));
      chk("mon_ready", 32'(push_ready), 32'(exp_q.size() <= DEPTH - 2));
      chk("mon_valid1", 32'(pop_valid1), 32'(mon_v.size() >= 1));
      chk("mon_valid2", 32'(pop_valid2), 32'(mon_v.size() >= 2));
      if (mon_v.size() >= 1) begin
        chk("mon_pc1", 32'(pop_pc1), 32'(mon_v[0].pc));
        chk("mon_inst1", pop_inst1, mon_v[0].inst);
      end else begin
        chk("mon_pc1_idle", 32'(pop_pc1), 32'h0);
        chk("mon_inst1_idle", pop_inst1, NOP);
      end
      if (mon_v.size() >= 2) begin
        chk("mon_pc2", 32'(pop_pc2), 32'(mon_v[1].pc));
        chk("mon_inst2", pop_inst2, mon_v[1].inst);
      end else begin
        chk("mon_pc2_idle", 32'(pop_pc2), 32'h0);
        chk("mon_inst2_idle", pop_inst2, NOP);
      end
    end
  end

  initial begin
    RST = 1'b1;
    idle();
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(push_ready), 32'h1);
    chk("rst_valid1", 32'(pop_valid1), 32'h0);
    chk("rst_valid2", 32'(pop_valid2), 32'h0);
    chk("rst_inst1", pop_inst1, NOP);
    chk("rst_inst2", pop_inst2, NOP);
    chk("rst_pc1", 32'(pop_pc1), 32'h0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    started = 1'b1;

    step(1, 1, 13'h000, 2'd0, 0, 1, 0);
    @(negedge CLK);
    chk("first_count", 32'(count), 32'h2);
    chk("first_valid1", 32'(pop_valid1), 32'h1);
    chk("first_valid2", 32'(pop_valid2), 32'h1);
    chk("first_pc1", 32'(pop_pc1), 32'h000);
    chk("first_pc2", 32'(pop_pc2), 32'h004);
    chk("first_inst1", pop_inst1, 32'h0010_0093);
    chk("first_inst2", pop_inst2, 32'h0020_0113);
    realign();

    step(1, 1, 13'h008, 2'd0, 0, 1, 0);
    step(1, 1, 13'h010, 2'd0, 0, 1, 0);
    step(1, 0, 13'h018, 2'd0, 0, 1, 0);
    @(negedge CLK);
    chk("full_count", 32'(count), 32'h7);
    chk("full_ready", 32'(push_ready), 32'h0);
    realign();
    step(1, 1, 13'h020, 2'd0, 0, 0, 0);
    @(negedge CLK);
    chk("ignored_push_count", 32'(count), 32'h7);
    realign();

    repeat (3) step(0, 0, 13'h000, 2'd2, 0, 0, 2);
    @(negedge CLK);
    chk("drain_count", 32'(count), 32'h1);
    chk("drain_pc1", 32'(pop_pc1), 32'h018);
    realign();
    step(0, 0, 13'h000, 2'd2, 0, 0, 1);
    @(negedge CLK);
    chk("clamp_count", 32'(count), 32'h0);
    chk("clamp_valid1", 32'(pop_valid1), 32'h0);
    chk("clamp_inst1", pop_inst1, NOP);
    realign();

    step(1, 1, 13'h100, 2'd0, 0, 1, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, 13'(13'h200 + 8 * i), 2'd2, 0, 1, 2);
    @(negedge CLK);
    chk("stream_count", 32'(count), 32'h2);
    chk("stream_pc1", 32'(pop_pc1), 32'h298);
    chk("stream_pc2", 32'(pop_pc2), 32'h29c);
    realign();

    step(1, 1, 13'h300, 2'd0, 0, 1, 0);
    step(1, 0, 13'h308, 2'd0, 0, 1, 0);
    @(negedge CLK);
    chk("preflush_count", 32'(count), 32'h5);
    realign();
    step(1, 0, 13'h310, 2'd2, 1, 0, 0);
    @(negedge CLK);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid1", 32'(pop_valid1), 32'h0);
    chk("flush_pc1", 32'(pop_pc1), 32'h0);
    realign();
    step(1, 1, 13'h400, 2'd0, 0, 1, 0);
    @(negedge CLK);
    chk("postflush_count", 32'(count), 32'h2);
    chk("postflush_pc1", 32'(pop_pc1), 32'h400);
    realign();
    step(0, 0, 13'h000, 2'd2, 0, 0, 2);

    drive(1, 1, 13'h010, 2'd1, 0);
    @(negedge CLK);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_valid1", 32'(pop_valid1), 32'h1);
    chk("byp_same_pc1", 32'(pop_pc1), 32'h010);
`else
    chk("byp_same_valid1", 32'(pop_valid1), 32'h0);
    chk("byp_same_pc1", 32'(pop_pc1), 32'h000);
`endif
    @(posedge CLK);
`ifdef FETCH_QUEUE_BYPASS_EN
    commit(0, 1, 1);
`else
    commit(0, 1, 0);
`endif
    #1 idle();
    @(negedge CLK);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_next_count", 32'(count), 32'h1);
    chk("byp_next_pc1", 32'(pop_pc1), 32'h014);
`else
    chk("byp_next_count", 32'(count), 32'h2);
    chk("byp_next_pc1", 32'(pop_pc1), 32'h010);
`endif
    realign();

    drive(1, 1, 13'h500, 2'd1, 0);
    #2 RST = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_valid1", 32'(pop_valid1), 32'h0);
    chk("midrst_ready", 32'(push_ready), 32'h1);
    chk("midrst_inst1", pop_inst1, NOP);
    @(posedge CLK);
    #1 idle();
    RST = 1'b0;
    step(1, 1, 13'h600, 2'd0, 0, 1, 0);
    @(negedge CLK);
    chk("afterrst_count", 32'(count), 32'h2);
    chk("afterrst_pc1", 32'(pop_pc1), 32'h600);
    chk("afterrst_pc2", 32'(pop_pc2), 32'h604);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of two, >=4).
REQ-002 SHALL have parameter PC_W, default 13, program-counter width.
REQ-003 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports push_valid1, push_valid2  in  1  fetch slot valids (slot2 honoured only with slot1).
REQ-006 SHALL have ports push_pc1, push_pc2  in  PC_W  fetched PCs.
REQ-007 SHALL have ports push_inst1, push_inst2  in  32  fetched instructions.
REQ-008 SHALL have port push_ready  out  1  high when free entries >= 2.
REQ-009 SHALL have port flush  in  1  mispredict redirect, discards all contents.
REQ-010 SHALL have port pop_count  in  2  entries consumed by the check stage this cycle (0..2).
REQ-011 SHALL have ports pop_valid1, pop_valid2  out  1  head / head+1 entries present.
REQ-012 SHALL have ports pop_pc1, pop_pc2  out  PC_W and pop_inst1, pop_inst2  out  32  head / head+1 entry contents.
REQ-013 SHALL have port count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL act as a circular FIFO of {pc, inst} with head/tail pointers wrapping modulo DEPTH.
REQ-015 SHALL accept pushes only when push_ready is high at the edge; pushes while push_ready low SHALL be ignored (upstream holds).
REQ-016 SHALL write slot1 at tail and slot2 at tail+1; pushes = push_valid1 + (push_valid1 & push_valid2).
REQ-017 SHALL clamp pops to min(pop_count, count); pop_count=3 SHALL be treated as 2.
REQ-018 SHALL update count = count + pushes - pops on a simultaneous push and pop; push_ready SHALL derive from the pre-edge count only.
REQ-019 SHALL drive pop_valid1 = (count>=1) and pop_valid2 = (count>=2) combinationally from registered state.
REQ-020 SHALL drive pop_inst = 32'h00000013 (NOP) and pop_pc = 0 on any slot whose pop_valid is low.
REQ-021 SHALL give flush highest priority: at the edge count, head and tail return to 0 and same-cycle pushes/pops are discarded.
REQ-022 SHALL, without bypass, give a minimum latency of one cycle from push to pop_valid.
REQ-023 SHALL never overflow or underflow; count SHALL stay within 0..DEPTH.

Reset
REQ-024 SHALL, while RST is high, force count=0, head=0, tail=0, push_ready=1, pop_valid1/2=0, pop_pc1/2=0 and pop_inst1/2=NOP, independent of CLK.
REQ-025 SHALL treat an RST assertion mid-operation as a full discard, with no partial writes committed.
REQ-026 SHALL accept its first push on the first rising edge after RST deasserts.

Configuration
REQ-027 SHALL provide macro FETCH_QUEUE_BYPASS_EN; when defined and count==0 with flush low, pop outputs SHALL present push slot data combinationally in the same cycle, and bypassed entries consumed by pop_count SHALL NOT be written.
REQ-028 SHALL, when FETCH_QUEUE_BYPASS_EN is undefined, give pop outputs that depend only on registered state (REQ-022 latency).

Verification
REQ-029 Bench SHALL check: reset, then push pc 0x000/0x004 (inst 0x00100093/0x00200113) with pop_count=0 -> next cycle count=2, pop_valid1/2=1, pop_pc1=0x000, pop_pc2=0x004.
REQ-030 Bench SHALL check: push pairs with pop_count=0 until count=7 -> push_ready=0; a further push is ignored and count stays 7.
REQ-031 Bench SHALL check: count=1 with pop_count=2 and no push -> count=0 and pop_valid1=0 with pop_inst1=0x00000013.
REQ-032 Bench SHALL check: 20 cycles of continuous 2-push/2-pop -> count holds constant, PCs emerge in order, and pointer wrap at DEPTH is seamless.
REQ-033 Bench SHALL check: count=5 with flush=1, push_valid1=1 and pop_count=2 -> next cycle count=0 and the pushed entry is absent.
REQ-034 Bench SHALL check: with FETCH_QUEUE_BYPASS_EN defined, count=0, push 0x010/0x014 and pop_count=1 -> same cycle pop_pc1=0x010, next cycle count=1 with pop_pc1=0x014.
